// File: rtl/adc_serial_receiver.sv
// Receive-side controller for a 16-bit SPI ADC frame (4 header bits + 12-bit sample, MSB first).
// Shifts one bit per SCLK rising edge while CS is low, then reports the raw frame and the sample in microvolts.
module adc_serial_receiver #(
    parameter logic [9:0] SCALE  = 10'd806,
    parameter int         N_BITS = 16
) (
    input  logic        SCLK,
    input  logic        reset,
    input  logic        CS,
    input  logic [15:0] datos,
    output logic        rx_done_tick,
    output logic [15:0] b_reg,
    output logic [21:0] data_Out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DONE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(N_BITS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_n;
    logic [15:0] r_b_reg;
    logic [21:0] r_data_out;

    logic        w_bit;
    logic        w_shift;
    logic        w_last;
    logic [15:0] w_b_next;
    logic [21:0] w_product;

    // The emulated SDATA line presents datos MSB first: frame bit n is datos[15-n].
    assign w_bit     = datos[4'd15 - r_n];
    assign w_shift   = (r_state == ST_DATA) && !CS;
    assign w_last    = w_shift && (r_n == LAST_BIT);
    assign w_b_next  = {r_b_reg[14:0], w_bit};
    // Both operands widened to 22 bits so the full 12x10 product is kept.
    assign w_product = {10'd0, w_b_next[11:0]} * {12'd0, SCALE};

    // State register
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of process ordering.
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (!CS) w_state_next = ST_DATA;
            ST_DATA: begin
                if (CS) begin
                    w_state_next = ST_IDLE;
                end else if (r_n == LAST_BIT) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = CS ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (CS) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        rx_done_tick = (r_state == ST_DONE);
        b_reg        = r_b_reg;
        data_Out     = r_data_out;
    end

    // Bit counter, shift register and scaled sample
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            r_n        <= 4'd0;
            r_b_reg    <= 16'd0;
            r_data_out <= 22'd0;
        end else begin
            if ((r_state == ST_IDLE) && !CS) begin
                r_n <= 4'd0;
            end else if (w_shift) begin
                r_n <= r_n + 4'd1;
            end

            if (w_shift) begin
                r_b_reg <= w_b_next;
            end

            if (w_last) begin
                r_data_out <= w_product;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_receiver.sv
// Self-checking bench for adc_serial_receiver: directed scenarios plus random frames,
// compared against a word-level model of the received frame and its microvolt scaling.
`timescale 1ns/1ps
module tb_adc_serial_receiver;

    localparam int SCALE = 806;

    logic        SCLK;
    logic        reset;
    logic        CS;
    logic [15:0] datos;
    logic        rx_done_tick;
    logic [15:0] b_reg;
    logic [21:0] data_Out;

    int checks = 0;
    int errors = 0;

    // Model state: what the DUT should currently hold.
    logic [31:0] mdl_b;
    logic [31:0] mdl_out;

    adc_serial_receiver dut (
        .SCLK        (SCLK),
        .reset       (reset),
        .CS          (CS),
        .datos       (datos),
        .rx_done_tick(rx_done_tick),
        .b_reg       (b_reg),
        .data_Out    (data_Out)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] scaled(input logic [31:0] word);
        return (word & 32'h0FFF) * SCALE;
    endfunction

    task automatic tick_edge();
        @(posedge SCLK);
        @(negedge SCLK);
    endtask

    // Full frame. The first m frame bits come from d1, the rest from d2.
    // CS stays low for 'extra' edges after the tick, then rises.
    task automatic run_frame(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                             input int m, input int extra);
        logic [31:0] hi_mask;
        logic [31:0] exp_word;
        int          ticks;
        hi_mask  = (32'hFFFF << (16 - m)) & 32'hFFFF;
        exp_word = ({16'd0, d1} & hi_mask) | ({16'd0, d2} & ~hi_mask & 32'hFFFF);
        ticks    = 0;
        CS = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            datos = ((k - 2) < m) ? d1 : d2;
            tick_edge();
            if (k < 17 && rx_done_tick === 1'b1) ticks++;
        end
        check({tag, " early_tick"}, ticks, 0);
        check({tag, " tick"}, {31'd0, rx_done_tick}, 1);
        check({tag, " b_reg"}, {16'd0, b_reg}, exp_word);
        check({tag, " data_Out"}, {10'd0, data_Out}, scaled(exp_word));
        mdl_b   = exp_word;
        mdl_out = scaled(exp_word);
        ticks = 0;
        for (int e = 0; e < extra; e++) begin
            datos = 16'($urandom);
            tick_edge();
            if (rx_done_tick !== 1'b0) ticks++;
        end
        CS = 1'b1;
        tick_edge();
        if (rx_done_tick !== 1'b0) ticks++;
        tick_edge();
        check({tag, " extra_ticks"}, ticks, 0);
        check({tag, " hold_b"}, {16'd0, b_reg}, mdl_b);
        check({tag, " hold_out"}, {10'd0, data_Out}, mdl_out);
    endtask

    initial begin
        logic [15:0] r1;
        logic [15:0] r2;
        int          m;
        int          extra;
        int          ticks;

        reset = 1'b0;
        CS    = 1'b1;
        datos = 16'h0000;
        mdl_b   = 32'd0;
        mdl_out = 32'd0;

        // Reset held for 5 cycles, then idle with CS high.
        repeat (5) @(negedge SCLK);
        check("reset b_reg", {16'd0, b_reg}, 0);
        check("reset data_Out", {10'd0, data_Out}, 0);
        check("reset tick", {31'd0, rx_done_tick}, 0);
        reset = 1'b1;
        ticks = 0;
        repeat (4) begin
            tick_edge();
            if (rx_done_tick !== 1'b0) ticks++;
        end
        check("idle ticks", ticks, 0);
        check("idle b_reg", {16'd0, b_reg}, 0);

        // Directed frames.
        run_frame("f0ABC", 16'h0ABC, 16'h0ABC, 16, 1);
        check("f0ABC abs", {10'd0, data_Out}, 32'd2214888);
        run_frame("fFFFF", 16'hFFFF, 16'hFFFF, 16, 0);
        check("fFFFF abs", {10'd0, data_Out}, 32'd3300570);
        run_frame("f0000", 16'h0000, 16'h0000, 16, 0);
        run_frame("long_cs", 16'h5A3C, 16'h5A3C, 16, 6);

        // Abort after 8 bits of 0x00FF.
        CS = 1'b0;
        datos = 16'h00FF;
        repeat (9) tick_edge();
        CS = 1'b1;
        ticks = 0;
        repeat (3) begin
            tick_edge();
            if (rx_done_tick !== 1'b0) ticks++;
        end
        check("abort ticks", ticks, 0);
        check("abort data_Out", {10'd0, data_Out}, mdl_out);
        check("abort b_reg", {16'd0, b_reg}, ((mdl_b << 8) | (32'h00FF >> 8)) & 32'hFFFF);
        run_frame("f0001", 16'h0001, 16'h0001, 16, 0);
        check("f0001 abs", {10'd0, data_Out}, 32'd806);

        // Reset pulsed at bit 10 of a frame.
        CS = 1'b0;
        datos = 16'hFFFF;
        repeat (11) tick_edge();
        reset = 1'b0;
        #1;
        check("midrst b_reg", {16'd0, b_reg}, 0);
        check("midrst data_Out", {10'd0, data_Out}, 0);
        check("midrst tick", {31'd0, rx_done_tick}, 0);
        mdl_b   = 32'd0;
        mdl_out = 32'd0;
        CS = 1'b1;
        @(negedge SCLK);
        reset = 1'b1;
        tick_edge();
        run_frame("f0800", 16'h0800, 16'h0800, 16, 0);
        check("f0800 abs", {10'd0, data_Out}, 32'd1650688);

        // Random frames, some with datos changing mid-frame.
        for (int i = 0; i < 12; i++) begin
            r1    = 16'($urandom);
            r2    = 16'($urandom);
            m     = (i % 2 == 0) ? 16 : int'($urandom_range(15, 0));
            extra = int'($urandom_range(4, 0));
            run_frame($sformatf("rnd%0d", i), r1, r2, m, extra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
